irq_controller: RTL and testbench

- Prioritising, non-nesting interrupt controller inside the microcontroller.
- Collects external interrupt pins (INT0/INT1) and timer compare events (tim1/tim2) as raw lines, synchronises them and latches them as pending.
- Presents one request at a time to the CPU core through a req/ack/done handshake.
- Configured by the CPU through a small register port on the peripheral bus.

---
 rtl/irq_controller.sv | 162 ++++++++++++++++
 tb/tb_irq_controller.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Prioritising, non-nesting interrupt controller. Each line has its own lane for
// sync, edge detect and pending. A fixed-priority picker feeds the req/ack/done FSM.

module irq_lane #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic irq_raw,
   input  logic edge_mode,
   input  logic clr,
   output logic pend
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   pend_q;
   logic                   sync_v;
   logic                   rise;

   assign sync_v = sync_q[SYNC_STAGES-1];
   assign rise   = sync_v & ~hist_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
         hist_q <= sync_v;
         // A level-mode lane stores nothing. A new rise beats a same-cycle clear.
         if (!edge_mode)
            pend_q <= 1'b0;
         else if (rise)
            pend_q <= 1'b1;
         else if (clr)
            pend_q <= 1'b0;
      end
   end

   assign pend = edge_mode ? pend_q : sync_v;
endmodule

module irq_controller #(
   parameter int NUM_IRQ     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int ID_W        = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [NUM_IRQ-1:0] cfg_wdata,
   output logic [NUM_IRQ-1:0] cfg_rdata,
   output logic               irq_req,
   output logic [ID_W-1:0]    irq_id,
   input  logic               irq_ack,
   input  logic               irq_done
);
   typedef enum logic [1:0] {ST_IDLE, ST_REQUEST, ST_SERVICE} state_t;

   state_t             state_q, state_d;
   logic [NUM_IRQ-1:0] enable_q, edge_q, insvc_q, insvc_d;
   logic [NUM_IRQ-1:0] pend, clr, eligible, ack_sel;
   logic [ID_W-1:0]    id_q, id_d, winner;
   logic               any_elig, pend_wr, ack_take;

   assign pend_wr  = cfg_we && (cfg_addr == 2'd2);
   assign ack_take = (state_q == ST_REQUEST) && irq_ack;

   always_comb begin
      ack_sel = '0;
      if (ack_take)
         ack_sel[id_q] = 1'b1;
   end

   assign clr = (pend_wr ? cfg_wdata : '0) | ack_sel;

   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_lane
      irq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
         .clk       (clk),
         .reset     (reset),
         .irq_raw   (irq_in[i]),
         .edge_mode (edge_q[i]),
         .clr       (clr[i]),
         .pend      (pend[i])
      );
   end

   assign eligible = pend & enable_q;
   assign any_elig = |eligible;

   // Scan from the top down so the lowest eligible index wins.
   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ-1; i >= 0; i--)
         if (eligible[i])
            winner = ID_W'(i);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         enable_q <= '0;
         edge_q   <= '0;
      end else if (cfg_we) begin
         case (cfg_addr)
            2'd0:    enable_q <= cfg_wdata;
            2'd1:    edge_q   <= cfg_wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         id_q    <= '0;
         insvc_q <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         insvc_q <= insvc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      insvc_d = insvc_q;
      case (state_q)
         ST_IDLE:
            if (any_elig) begin
               state_d = ST_REQUEST;
               id_d    = winner;
            end
         ST_REQUEST:
            if (irq_ack) begin
               state_d = ST_SERVICE;
               insvc_d = ack_sel;
            end
         ST_SERVICE:
            if (irq_done) begin
               state_d = ST_IDLE;
               insvc_d = '0;
            end
         default: state_d = ST_IDLE;
      endcase
   end

   assign irq_req = (state_q == ST_REQUEST);
   assign irq_id  = id_q;

   always_comb begin
      case (cfg_addr)
         2'd0:    cfg_rdata = enable_q;
         2'd1:    cfg_rdata = edge_q;
         2'd2:    cfg_rdata = pend;
         default: cfg_rdata = insvc_q;
      endcase
   end
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller. It runs directed scenarios and then a randomized run
// that is checked against a sample-history reference model.

module tb_irq_controller;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] irq_in = '0;
   logic         cfg_we = 1'b0;
   logic [1:0]   cfg_addr = 2'd0;
   logic [N-1:0] cfg_wdata = '0;
   logic [N-1:0] cfg_rdata;
   logic         irq_req;
   logic [1:0]   irq_id;
   logic         irq_ack = 1'b0;
   logic         irq_done = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   irq_controller #(.NUM_IRQ(N), .SYNC_STAGES(2), .ID_W(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .irq_in    (irq_in),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .irq_req   (irq_req),
      .irq_id    (irq_id),
      .irq_ack   (irq_ack),
      .irq_done  (irq_done)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [N-1:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0; cfg_wdata = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [N-1:0] d);
      cfg_addr = a;
      #1 d = cfg_rdata;
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
   endtask

   task automatic pulse_done();
      irq_done = 1'b1; @(negedge clk); irq_done = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0; irq_in = '0; irq_ack = 1'b0; irq_done = 1'b0; cfg_we = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(4);
   endtask

   task automatic wait_req(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (irq_req === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [N-1:0] v;
      reset = 1'b0; irq_in = 4'hF;
      cyc(3);
      tests++;
      if (irq_req !== 1'b0 || irq_id !== 2'd0) begin
         fails++; $display("FAIL reset_out: req=%b id=%0d expected req=0 id=0", irq_req, irq_id);
      end
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), v);
         tests++;
         if (v !== 4'h0) begin fails++; $display("FAIL reset_reg%0d: got %h expected 0", a, v); end
      end
      reset = 1'b1;
      cyc(4);
      rd(2'd2, v);
      tests++;
      if (v !== 4'hF) begin fails++; $display("FAIL reset_level_pend: got %h expected f", v); end
      tests++;
      if (irq_req !== 1'b0) begin fails++; $display("FAIL reset_no_req: got %b expected 0", irq_req); end
      irq_in = '0;
   endtask

   task automatic test_edge_latency();
      logic [N-1:0] v;
      do_reset();
      wr(2'd0, 4'b0010);
      wr(2'd1, 4'b0010);
      cyc(1);
      irq_in = 4'b0010; cyc(1);
      irq_in = '0;      cyc(1);
      rd(2'd2, v);
      tests++;
      if (v !== 4'h0) begin fails++; $display("FAIL lat_pend_early: got %h expected 0", v); end
      cyc(1);
      rd(2'd2, v);
      tests++;
      if (v !== 4'b0010 || irq_req !== 1'b0) begin
         fails++; $display("FAIL lat_pend: pend=%h req=%b expected pend=2 req=0", v, irq_req);
      end
      cyc(1);
      tests++;
      if (irq_req !== 1'b1 || irq_id !== 2'd1) begin
         fails++; $display("FAIL lat_req: req=%b id=%0d expected req=1 id=1", irq_req, irq_id);
      end
      pulse_ack();
      rd(2'd2, v);
      tests++;
      if (v !== 4'h0 || irq_req !== 1'b0) begin
         fails++; $display("FAIL lat_ack: pend=%h req=%b expected pend=0 req=0", v, irq_req);
      end
      rd(2'd3, v);
      tests++;
      if (v !== 4'b0010) begin fails++; $display("FAIL lat_insvc: got %h expected 2", v); end
      pulse_done();
      rd(2'd3, v);
      tests++;
      if (v !== 4'h0) begin fails++; $display("FAIL lat_done: insvc=%h expected 0", v); end
   endtask

   task automatic test_priority_hold();
      logic [N-1:0] v;
      bit ok;
      do_reset();
      wr(2'd0, 4'hF);
      wr(2'd1, 4'hF);
      cyc(1);
      irq_in = 4'b1010; cyc(1); irq_in = '0;
      wait_req(10, ok);
      tests++;
      if (!ok || irq_id !== 2'd1) begin
         fails++; $display("FAIL prio_first: ok=%b id=%0d expected ok=1 id=1", ok, irq_id);
      end
      irq_in = 4'b0001; cyc(1); irq_in = '0;
      cyc(5);
      rd(2'd2, v);
      tests++;
      if (irq_req !== 1'b1 || irq_id !== 2'd1 || v !== 4'b1011) begin
         fails++; $display("FAIL prio_hold: req=%b id=%0d pend=%h expected req=1 id=1 pend=b", irq_req, irq_id, v);
      end
      pulse_ack();
      rd(2'd2, v);
      tests++;
      if (v !== 4'b1001) begin fails++; $display("FAIL prio_ack_clr: pend=%h expected 9", v); end
      pulse_done();
      wait_req(10, ok);
      tests++;
      if (!ok || irq_id !== 2'd0) begin
         fails++; $display("FAIL prio_second: ok=%b id=%0d expected ok=1 id=0", ok, irq_id);
      end
      pulse_ack(); pulse_done();
      wait_req(10, ok);
      tests++;
      if (!ok || irq_id !== 2'd3) begin
         fails++; $display("FAIL prio_third: ok=%b id=%0d expected ok=1 id=3", ok, irq_id);
      end
      pulse_ack(); pulse_done();
      cyc(2);
      rd(2'd2, v);
      tests++;
      if (v !== 4'h0 || irq_req !== 1'b0) begin
         fails++; $display("FAIL prio_drain: pend=%h req=%b expected pend=0 req=0", v, irq_req);
      end
   endtask

   task automatic test_w1c_set_wins();
      logic [N-1:0] v;
      do_reset();
      wr(2'd1, 4'b0100);
      cyc(1);
      irq_in = 4'b0100; cyc(1); irq_in = '0;
      cyc(4);
      rd(2'd2, v);
      tests++;
      if (v !== 4'b0100) begin fails++; $display("FAIL w1c_pend: got %h expected 4", v); end
      irq_in = 4'b0100; cyc(1); irq_in = '0;
      cyc(1);
      wr(2'd2, 4'b0100);
      rd(2'd2, v);
      tests++;
      if (v !== 4'b0100) begin fails++; $display("FAIL w1c_set_wins: got %h expected 4", v); end
      wr(2'd2, 4'b0100);
      rd(2'd2, v);
      tests++;
      if (v !== 4'h0) begin fails++; $display("FAIL w1c_clear: got %h expected 0", v); end
   endtask

   task automatic test_level_rerequest();
      logic [N-1:0] v;
      bit ok;
      do_reset();
      wr(2'd0, 4'b0001);
      irq_in = 4'b0001;
      wait_req(10, ok);
      tests++;
      if (!ok || irq_id !== 2'd0) begin
         fails++; $display("FAIL lvl_req: ok=%b id=%0d expected ok=1 id=0", ok, irq_id);
      end
      pulse_ack();
      rd(2'd3, v);
      tests++;
      if (irq_req !== 1'b0 || v !== 4'b0001) begin
         fails++; $display("FAIL lvl_ack: req=%b insvc=%h expected req=0 insvc=1", irq_req, v);
      end
      cyc(2);
      tests++;
      if (irq_req !== 1'b0) begin fails++; $display("FAIL lvl_svc_quiet: req=%b expected 0", irq_req); end
      irq_done = 1'b1; cyc(1); irq_done = 1'b0;
      tests++;
      if (irq_req !== 1'b0) begin fails++; $display("FAIL lvl_done_gap: req=%b expected 0", irq_req); end
      cyc(1);
      tests++;
      if (irq_req !== 1'b1 || irq_id !== 2'd0) begin
         fails++; $display("FAIL lvl_rereq: req=%b id=%0d expected req=1 id=0", irq_req, irq_id);
      end
      pulse_ack();
      irq_in = '0;
      cyc(4);
      pulse_done();
      cyc(4);
      rd(2'd3, v);
      tests++;
      if (irq_req !== 1'b0 || v !== 4'h0) begin
         fails++; $display("FAIL lvl_dropped: req=%b insvc=%h expected req=0 insvc=0", irq_req, v);
      end
   endtask

   task automatic test_spurious();
      logic [N-1:0] v;
      bit ok;
      do_reset();
      wr(2'd0, 4'b0011);
      wr(2'd1, 4'b0011);
      pulse_done();
      rd(2'd3, v);
      tests++;
      if (irq_req !== 1'b0 || v !== 4'h0) begin
         fails++; $display("FAIL spur_done_idle: req=%b insvc=%h expected req=0 insvc=0", irq_req, v);
      end
      irq_in = 4'b0001; cyc(1); irq_in = '0;
      wait_req(10, ok);
      pulse_done();
      tests++;
      if (!ok || irq_req !== 1'b1 || irq_id !== 2'd0) begin
         fails++; $display("FAIL spur_done_req: ok=%b req=%b id=%0d expected ok=1 req=1 id=0", ok, irq_req, irq_id);
      end
      pulse_ack();
      irq_in = 4'b0010; cyc(1); irq_in = '0;
      cyc(4);
      pulse_ack();
      rd(2'd3, v);
      tests++;
      if (irq_req !== 1'b0 || v !== 4'b0001) begin
         fails++; $display("FAIL spur_ack_svc: req=%b insvc=%h expected req=0 insvc=1", irq_req, v);
      end
      rd(2'd2, v);
      tests++;
      if (v !== 4'b0010) begin fails++; $display("FAIL spur_keep_pend: pend=%h expected 2", v); end
      reset = 1'b0; cyc(1); reset = 1'b1;
      rd(2'd3, v);
      tests++;
      if (irq_req !== 1'b0 || v !== 4'h0) begin
         fails++; $display("FAIL spur_reset_svc: req=%b insvc=%h expected req=0 insvc=0", irq_req, v);
      end
      rd(2'd0, v);
      tests++;
      if (v !== 4'h0) begin fails++; $display("FAIL spur_reset_en: got %h expected 0", v); end
      cyc(3);
   endtask

   // Reference model: s0/s1/s2 hold the last three irq_in samples. The synchronised
   // view is s1 and the previous one is s2. Handshake phases are plain flags.
   task automatic test_random();
      logic [N-1:0] m_en, m_edge, m_pst, m_insvc, m_pend, elig, rise, clr, s0, s1, s2;
      logic [N-1:0] n_in, wd, exp_rd;
      logic [1:0]   ad;
      bit           m_req, m_svc, we, ak, dn, rs;
      int           m_id;
      reset = 1'b0; irq_in = '0; irq_ack = 1'b0; irq_done = 1'b0; cfg_we = 1'b0;
      cyc(2);
      m_en = '0; m_edge = '0; m_pst = '0; m_insvc = '0; s0 = '0; s1 = '0; s2 = '0;
      m_req = 1'b0; m_svc = 1'b0; m_id = 0;
      for (int c = 0; c < 1500; c++) begin
         m_pend = (m_edge & m_pst) | (~m_edge & s1);
         tests++;
         if (irq_req !== m_req) begin
            fails++; $display("FAIL rand_req cyc=%0d: got %b expected %b", c, irq_req, m_req);
         end
         if (m_req) begin
            tests++;
            if (irq_id !== 2'(m_id)) begin
               fails++; $display("FAIL rand_id cyc=%0d: got %0d expected %0d", c, irq_id, m_id);
            end
         end
         n_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : irq_in;
         rs   = (c == 0) || ($urandom_range(0, 249) != 0);
         ak   = ($urandom_range(0, 3) == 0);
         dn   = ($urandom_range(0, 3) == 0);
         we   = ($urandom_range(0, 3) == 0);
         ad   = 2'($urandom);
         wd   = 4'($urandom);
         reset = rs; irq_in = n_in; irq_ack = ak; irq_done = dn;
         cfg_we = we; cfg_addr = ad; cfg_wdata = wd;
         #1;
         case (ad)
            2'd0:    exp_rd = m_en;
            2'd1:    exp_rd = m_edge;
            2'd2:    exp_rd = m_pend;
            default: exp_rd = m_insvc;
         endcase
         tests++;
         if (cfg_rdata !== exp_rd) begin
            fails++; $display("FAIL rand_rdata cyc=%0d addr=%0d: got %h expected %h", c, ad, cfg_rdata, exp_rd);
         end
         if (!rs) begin
            m_en = '0; m_edge = '0; m_pst = '0; m_insvc = '0; s0 = '0; s1 = '0; s2 = '0;
            m_req = 1'b0; m_svc = 1'b0; m_id = 0;
         end else begin
            rise = s1 & ~s2;
            elig = m_pend & m_en;
            clr  = (we && ad == 2'd2) ? wd : '0;
            if (m_req && ak) clr[m_id] = 1'b1;
            if (m_svc) begin
               if (dn) begin m_svc = 1'b0; m_insvc = '0; end
            end else if (m_req) begin
               if (ak) begin m_req = 1'b0; m_svc = 1'b1; m_insvc = 4'(1 << m_id); end
            end else if (elig != '0) begin
               m_req = 1'b1;
               m_id = 0;
               while (!elig[m_id]) m_id++;
            end
            m_pst = m_edge & (rise | (m_pst & ~clr));
            if (we && ad == 2'd0) m_en = wd;
            if (we && ad == 2'd1) m_edge = wd;
            s2 = s1; s1 = s0; s0 = n_in;
         end
         @(negedge clk);
      end
      reset = 1'b1; irq_ack = 1'b0; irq_done = 1'b0; cfg_we = 1'b0; irq_in = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_edge_latency();
      test_priority_hold();
      test_w1c_set_wins();
      test_level_rerequest();
      test_spurious();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
